// File: rtl/binary_decoder_2to4_if.sv
// Select/enable bundle for the binary-to-one-hot decoder: the controller drives sel/en,
// and the decoder returns the combinational strobes plus their registered copy.
interface binary_decoder_2to4_if #(
   parameter int N = 2
);
   logic [N-1:0]        sel;
   logic                en;
   logic [(1<<N)-1:0]   out;
   logic [(1<<N)-1:0]   out_q;
   logic                en_q;

   modport master (
      output sel,
      output en,
      input  out,
      input  out_q,
      input  en_q
   );

   modport slave (
      input  sel,
      input  en,
      output out,
      output out_q,
      output en_q
   );
endinterface

// File: rtl/binary_decoder_2to4.sv
// N-bit binary-to-one-hot decoder with active-high enable, a combinational output
// and a one-cycle registered copy qualified by a registered enable flag.
module binary_decoder_2to4 #(
   parameter int N = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   binary_decoder_2to4_if.slave    bus
);
   localparam int W = 1 << N;

   logic [W-1:0] dec_d;
   logic [W-1:0] dec_q;
   logic         en_d;
   logic         en_q;

   always_comb begin
      dec_d = '0;
      en_d  = bus.en;
      if (bus.en) begin
         dec_d[bus.sel] = 1'b1;
      end
   end

   // Registers update every cycle; reset clears them without waiting for an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dec_q <= '0;
         en_q  <= 1'b0;
      end else begin
         dec_q <= dec_d;
         en_q  <= en_d;
      end
   end

   assign bus.out   = dec_d;
   assign bus.out_q = dec_q;
   assign bus.en_q  = en_q;
endmodule

// File: tb/tb_binary_decoder_2to4.sv
// Directed and random checks of the decoder at N=2 and N=3, with immediate assertions.
module tb_binary_decoder_2to4;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   binary_decoder_2to4_if #(.N(2)) bus2 ();
   binary_decoder_2to4_if #(.N(3)) bus3 ();

   binary_decoder_2to4 #(.N(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
   binary_decoder_2to4 #(.N(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_inv(input string tag);
      check({tag, "_pop_out2"}, 8'($countones(bus2.out)), {7'd0, bus2.en});
      check({tag, "_pop_outq2"}, 8'($countones(bus2.out_q)), {7'd0, bus2.en_q});
      if (!bus2.en_q) check({tag, "_outq_zero2"}, {4'd0, bus2.out_q}, 8'h00);
      check({tag, "_pop_out3"}, 8'($countones(bus3.out)), {7'd0, bus3.en});
      check({tag, "_pop_outq3"}, 8'($countones(bus3.out_q)), {7'd0, bus3.en_q});
   endtask

   initial begin
      logic [3:0] exp2;
      logic [3:0] exp2_q;
      logic       exp_en_q;
      logic [7:0] exp3;
      logic [7:0] one8;
      logic [3:0] one4;
      n_checks = 0;
      n_fail   = 0;
      one4 = 4'b0001;
      one8 = 8'h01;
      rst = 1'b1;
      bus2.sel = '0; bus2.en = 1'b0;
      bus3.sel = '0; bus3.en = 1'b0;
      #1;
      check("reset_outq", {4'd0, bus2.out_q}, 8'h00);
      check("reset_enq", {7'd0, bus2.en_q}, 8'h00);
      check("reset_outq3", bus3.out_q, 8'h00);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Disabled sweep
      for (int s = 0; s < 4; s++) begin
         bus2.sel = 2'(s); bus2.en = 1'b0;
         #1 check("dis_out", {4'd0, bus2.out}, 8'h00);
         @(posedge clk); #1;
         check("dis_outq", {4'd0, bus2.out_q}, 8'h00);
         check("dis_enq", {7'd0, bus2.en_q}, 8'h00);
         check_inv("dis");
         @(negedge clk);
      end

      // Enabled sweep
      for (int s = 0; s < 4; s++) begin
         bus2.sel = 2'(s); bus2.en = 1'b1;
         exp2 = one4 << s;
         #1 check("en_out", {4'd0, bus2.out}, {4'd0, exp2});
         @(posedge clk); #1;
         check("en_outq", {4'd0, bus2.out_q}, {4'd0, exp2});
         check("en_enq", {7'd0, bus2.en_q}, 8'h01);
         check_inv("en");
         @(negedge clk);
      end

      // Enable toggle at sel=2
      bus2.sel = 2'd2;
      bus2.en = 1'b1; #1 check("tog1_out", {4'd0, bus2.out}, 8'h04);
      @(posedge clk); #1 check("tog1_outq", {4'd0, bus2.out_q}, 8'h04);
      @(negedge clk);
      bus2.en = 1'b0; #1 check("tog0_out", {4'd0, bus2.out}, 8'h00);
      check("tog0_outq_lag", {4'd0, bus2.out_q}, 8'h04);
      @(posedge clk); #1 check("tog0_outq", {4'd0, bus2.out_q}, 8'h00);
      check("tog0_enq", {7'd0, bus2.en_q}, 8'h00);
      @(negedge clk);
      bus2.en = 1'b1; #1 check("tog2_out", {4'd0, bus2.out}, 8'h04);
      @(posedge clk); #1 check("tog2_outq", {4'd0, bus2.out_q}, 8'h04);
      check("tog2_enq", {7'd0, bus2.en_q}, 8'h01);

      // Async reset mid-operation
      @(negedge clk);
      bus2.sel = 2'd3; bus2.en = 1'b1;
      @(posedge clk); #1 check("ar_pre_outq", {4'd0, bus2.out_q}, 8'h08);
      #2 rst = 1'b1;
      #1 check("ar_outq", {4'd0, bus2.out_q}, 8'h00);
      check("ar_enq", {7'd0, bus2.en_q}, 8'h00);
      check("ar_out", {4'd0, bus2.out}, 8'h08);
      @(posedge clk); #1 check("ar_hold_outq", {4'd0, bus2.out_q}, 8'h00);
      check("ar_hold_enq", {7'd0, bus2.en_q}, 8'h00);
      @(negedge clk) rst = 1'b0;
      #1 check("ar_rel_outq", {4'd0, bus2.out_q}, 8'h00);
      @(posedge clk); #1 check("ar_post_outq", {4'd0, bus2.out_q}, 8'h08);
      check("ar_post_enq", {7'd0, bus2.en_q}, 8'h01);

      // N=3 exhaustive
      for (int e = 0; e < 2; e++) begin
         for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            bus3.sel = 3'(s); bus3.en = e[0];
            exp3 = e[0] ? (one8 << s) : 8'h00;
            #1 check("n3_out", bus3.out, exp3);
            @(posedge clk); #1;
            check("n3_outq", bus3.out_q, exp3);
            check("n3_enq", {7'd0, bus3.en_q}, {7'd0, e[0]});
            check_inv("n3");
         end
      end

      // Random with sporadic reset
      exp2_q = bus2.out_q;
      exp_en_q = bus2.en_q;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         bus2.sel = 2'($urandom_range(0, 3));
         bus2.en  = 1'($urandom_range(0, 1));
         rst = ($urandom_range(0, 19) == 0);
         exp2 = bus2.en ? (one4 << bus2.sel) : 4'd0;
         #1 check("rnd_out", {4'd0, bus2.out}, {4'd0, exp2});
         if (rst) begin
            check("rnd_rst_outq", {4'd0, bus2.out_q}, 8'h00);
            check("rnd_rst_enq", {7'd0, bus2.en_q}, 8'h00);
         end else begin
            check("rnd_hold_outq", {4'd0, bus2.out_q}, {4'd0, exp2_q});
         end
         exp2_q   = rst ? 4'd0 : exp2;
         exp_en_q = rst ? 1'b0 : bus2.en;
         @(posedge clk); #1;
         check("rnd_outq", {4'd0, bus2.out_q}, {4'd0, exp2_q});
         check("rnd_enq", {7'd0, bus2.en_q}, {7'd0, exp_en_q});
         check_inv("rnd");
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
